de0_cv_seg7_hex_driver: RTL and testbench



---
 rtl/de0_cv_seg7_pkg.sv | 18 +
 rtl/de0_cv_seg7_decode.sv | 9 +
 rtl/de0_cv_seg7_hex_driver.sv | 75 +++++++
 tb/tb_de0_cv_seg7_hex_driver.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/de0_cv_seg7_pkg.sv
// de0_cv_seg7_pkg: glyph table, blank code, PWM period and frame snapshot type
package de0_cv_seg7_pkg;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam int PWM_PERIOD = 15;
  localparam logic [15:0][6:0] GLYPHS = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
  typedef struct packed {
    logic [23:0] digits;
    logic        lz;
    logic [5:0]  blink;
    logic [3:0]  bright;
  } snap_t;
  function automatic logic [6:0] glyph(input logic [3:0] n);
    return GLYPHS[n];
  endfunction
endpackage

// File: rtl/de0_cv_seg7_decode.sv
// de0_cv_seg7_decode: nibble_i (4) -> active-low seg_o (7, bit0=a..bit6=g)
module de0_cv_seg7_decode
  import de0_cv_seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = glyph(nibble_i);
endmodule

// File: rtl/de0_cv_seg7_hex_driver.sv
// de0_cv_seg7_hex_driver: digits_in/blank_lz/blink_en/brightness snapshotted per frame -> PWM/blinked active-low hex0..hex5 plus frame_strobe
module de0_cv_seg7_hex_driver
  import de0_cv_seg7_pkg::*;
#(
  parameter int CLK_DIV      = 1000,
  parameter int BLINK_FRAMES = 1667
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [23:0] digits_in,
  input  logic        blank_lz,
  input  logic [5:0]  blink_en,
  input  logic [3:0]  brightness,
  output logic [6:0]  hex0,
  output logic [6:0]  hex1,
  output logic [6:0]  hex2,
  output logic [6:0]  hex3,
  output logic [6:0]  hex4,
  output logic [6:0]  hex5,
  output logic        frame_strobe
);
  localparam int TW = $clog2(CLK_DIV + 1);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  logic [TW-1:0] tick_q, tick_d;
  logic [3:0] pwm_q, pwm_d;
  logic [FW-1:0] frame_q, frame_d;
  logic phase_q, phase_d;
  snap_t snap_q, snap_d;
  logic [5:0][6:0] hex_q, hex_d, seg_w;
  logic [5:0] blank;
  logic strobe_q;
  logic tick, fb, fwrap;
  assign tick = tick_q == TW'(CLK_DIV - 1);
  assign fb = tick && pwm_q == 4'(PWM_PERIOD - 1);
  assign fwrap = frame_q == FW'(BLINK_FRAMES - 1);
  always_comb begin
    tick_d = tick ? '0 : tick_q + 1'b1;
    pwm_d = !tick ? pwm_q : fb ? '0 : pwm_q + 1'b1;
    frame_d = !fb ? frame_q : fwrap ? '0 : frame_q + 1'b1;
    phase_d = phase_q ^ (fb && fwrap);
    snap_d = fb ? {digits_in, blank_lz, blink_en, brightness} : snap_q;
  end
  genvar n;
  for (n = 0; n < 6; n++) begin : g_dec
    de0_cv_seg7_decode u_dec (.nibble_i(snap_q.digits[4*n+:4]), .seg_o(seg_w[n]));
  end
  always_comb begin
    blank = '0;
    blank[5] = snap_q.lz && snap_q.digits[23:20] == 4'd0;
    for (int i = 4; i > 0; i--) blank[i] = snap_q.lz && snap_q.digits[4*i+:4] == 4'd0 && blank[i+1];
    for (int i = 0; i < 6; i++)
      hex_d[i] = !blank[i] && pwm_q < snap_q.bright && !(snap_q.blink[i] && phase_q) ? seg_w[i] : SEG_BLANK;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tick_q   <= '0;
      pwm_q    <= '0;
      frame_q  <= '0;
      phase_q  <= 1'b0;
      snap_q   <= '0;
      hex_q    <= {6{SEG_BLANK}};
      strobe_q <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      pwm_q    <= pwm_d;
      frame_q  <= frame_d;
      phase_q  <= phase_d;
      snap_q   <= snap_d;
      hex_q    <= hex_d;
      strobe_q <= fb;
    end
  end
  assign {hex5, hex4, hex3, hex2, hex1, hex0} = hex_q;
  assign frame_strobe = strobe_q;
endmodule

// File: tb/tb_de0_cv_seg7_hex_driver.sv
// tb_de0_cv_seg7_hex_driver: randomized scenario tasks checked against a cycle-indexed reference model
module tb_de0_cv_seg7_hex_driver;
  localparam int CD = 2;
  localparam int BF = 3;
  localparam int FR = 15 * CD;
  typedef logic [5:0][6:0] hexv_t;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [23:0] digits_in = '0;
  logic blank_lz = 1'b0;
  logic [5:0] blink_en = '0;
  logic [3:0] brightness = '0;
  hexv_t h;
  logic frame_strobe;
  int cmp = 0;
  int errs = 0;
  int cyc;
  logic [23:0] md;
  logic mlz;
  logic [5:0] mbl;
  logic [3:0] mbr;
  hexv_t ex_h;
  logic ex_s;
  logic [6:0] GL [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  de0_cv_seg7_hex_driver #(.CLK_DIV(CD), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .reset_n(reset_n), .digits_in(digits_in), .blank_lz(blank_lz),
    .blink_en(blink_en), .brightness(brightness),
    .hex0(h[0]), .hex1(h[1]), .hex2(h[2]), .hex3(h[3]), .hex4(h[4]), .hex5(h[5]),
    .frame_strobe(frame_strobe)
  );
  always #5 clk = ~clk;
  function automatic hexv_t ref_hex(int c, logic [23:0] d, logic lz, logic [5:0] bl, logic [3:0] br);
    int pwm = (c / CD) % 15;
    int ph = (c / FR / BF) % 2;
    int top = 0;
    hexv_t r;
    for (int n = 0; n < 6; n++) if (d[4*n+:4] != 4'd0) top = n;
    for (int n = 0; n < 6; n++)
      r[n] = ((lz && n > top) || pwm >= int'(br) || (bl[n] && ph == 1)) ? 7'h7F : GL[d[4*n+:4]];
    return r;
  endfunction
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc <= 0;
      md <= '0;
      mlz <= 1'b0;
      mbl <= '0;
      mbr <= '0;
      ex_h <= {6{7'h7F}};
      ex_s <= 1'b0;
    end else begin
      ex_h <= ref_hex(cyc, md, mlz, mbl, mbr);
      ex_s <= (cyc % FR) == FR - 1;
      if ((cyc % FR) == FR - 1) begin
        md <= digits_in;
        mlz <= blank_lz;
        mbl <= blink_en;
        mbr <= brightness;
      end
      cyc <= cyc + 1;
    end
  end
  task automatic wait_strobe(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!frame_strobe && k < 100);
  endtask
  task automatic test_reset;
    int n = 0;
    reset_n = 1'b0;
    digits_in = 24'hFEDCBA;
    brightness = 4'd15;
    blank_lz = 1'b0;
    blink_en = '0;
    repeat (5) @(negedge clk);
    cmp++;
    if (h !== {6{7'h7F}} || frame_strobe !== 1'b0) begin
      errs++;
      $display("FAIL reset_hold got=%h/%b exp=%h/0", h, frame_strobe, {6{7'h7F}});
    end
    reset_n = 1'b1;
    while (!frame_strobe && n < 100) begin
      @(negedge clk);
      n++;
      cmp++;
      if (h !== {6{7'h7F}}) begin
        errs++;
        $display("FAIL reset_dark n=%0d got=%h exp=%h", n, h, {6{7'h7F}});
      end
    end
    cmp++;
    if (n != FR) begin
      errs++;
      $display("FAIL first_strobe got=%0d exp=%0d", n, FR);
    end
  endtask
  task automatic test_hex_pattern;
    repeat (FR) begin
      @(negedge clk);
      cmp++;
      if (h[0] !== 7'h08 || h[5] !== 7'h0E || h !== ex_h || frame_strobe !== ex_s) begin
        errs++;
        $display("FAIL hex_pattern got=%h/%b exp=%h/%b", h, frame_strobe, ex_h, ex_s);
      end
    end
  endtask
  task automatic test_lz;
    int k;
    digits_in = 24'h000100;
    blank_lz = 1'b1;
    wait_strobe(k);
    @(negedge clk);
    cmp++;
    if (k >= 100 || h !== {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40} || h !== ex_h) begin
      errs++;
      $display("FAIL lz_000100 got=%h exp=%h k=%0d", h, {7'h7F, 7'h7F, 7'h7F, 7'h79, 7'h40, 7'h40}, k);
    end
    digits_in = '0;
    wait_strobe(k);
    @(negedge clk);
    cmp++;
    if (k >= 100 || h !== {{5{7'h7F}}, 7'h40} || h !== ex_h) begin
      errs++;
      $display("FAIL lz_zero got=%h exp=%h k=%0d", h, {{5{7'h7F}}, 7'h40}, k);
    end
  endtask
  task automatic test_mid_frame;
    int k;
    blank_lz = 1'b0;
    digits_in = '0;
    wait_strobe(k);
    @(negedge clk);
    repeat (14) @(negedge clk);
    digits_in = 24'h888888;
    k = 0;
    do begin
      @(negedge clk);
      k++;
      cmp++;
      if (h !== {6{7'h40}} || h !== ex_h) begin
        errs++;
        $display("FAIL mid_hold k=%0d got=%h exp=%h", k, h, {6{7'h40}});
      end
    end while (!frame_strobe && k < 100);
    @(negedge clk);
    cmp++;
    if (k >= 100 || h !== {6{7'h00}} || h !== ex_h) begin
      errs++;
      $display("FAIL mid_update got=%h exp=%h k=%0d", h, {6{7'h00}}, k);
    end
  endtask
  task automatic test_pwm;
    int k;
    int lit [6];
    brightness = 4'd5;
    wait_strobe(k);
    for (int i = 0; i < 6; i++) lit[i] = 0;
    repeat (FR) begin
      @(negedge clk);
      for (int i = 0; i < 6; i++) if (h[i] != 7'h7F) lit[i]++;
      cmp++;
      if (h !== ex_h) begin
        errs++;
        $display("FAIL pwm5_model got=%h exp=%h", h, ex_h);
      end
    end
    for (int i = 0; i < 6; i++) begin
      cmp++;
      if (k >= 100 || lit[i] != 10) begin
        errs++;
        $display("FAIL pwm5_duty digit=%0d got=%0d exp=10", i, lit[i]);
      end
    end
    brightness = 4'd0;
    wait_strobe(k);
    repeat (FR) begin
      @(negedge clk);
      cmp++;
      if (k >= 100 || h !== {6{7'h7F}}) begin
        errs++;
        $display("FAIL pwm0_dark got=%h exp=%h", h, {6{7'h7F}});
      end
    end
  endtask
  task automatic test_blink;
    int k;
    int lit0 = 0;
    int dark_hi = 0;
    brightness = 4'd15;
    blink_en = 6'b000001;
    digits_in = 24'($urandom);
    wait_strobe(k);
    repeat (6 * FR) begin
      @(negedge clk);
      if (h[0] != 7'h7F) lit0++;
      for (int i = 1; i < 6; i++) if (h[i] == 7'h7F) dark_hi++;
      cmp++;
      if (h !== ex_h) begin
        errs++;
        $display("FAIL blink_model got=%h exp=%h", h, ex_h);
      end
    end
    cmp++;
    if (k >= 100 || lit0 != 3 * FR || dark_hi != 0) begin
      errs++;
      $display("FAIL blink_duty got lit0=%0d dark_hi=%0d exp lit0=%0d dark_hi=0", lit0, dark_hi, 3 * FR);
    end
    blink_en = '0;
  endtask
  task automatic test_random;
    repeat (25) begin
      digits_in = 24'($urandom);
      if ($urandom_range(0, 2) == 0) digits_in = digits_in >> (4 * $urandom_range(1, 6));
      blank_lz = 1'($urandom);
      blink_en = 6'($urandom);
      brightness = 4'($urandom);
      repeat ($urandom_range(1, 60)) begin
        @(negedge clk);
        cmp++;
        if (h !== ex_h || frame_strobe !== ex_s) begin
          errs++;
          $display("FAIL random cyc=%0d got=%h/%b exp=%h/%b", cyc, h, frame_strobe, ex_h, ex_s);
        end
      end
    end
  endtask
  task automatic test_reset_mid;
    int n = 0;
    repeat (17) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    cmp++;
    if (h !== {6{7'h7F}} || frame_strobe !== 1'b0) begin
      errs++;
      $display("FAIL reset_mid_async got=%h/%b exp=%h/0", h, frame_strobe, {6{7'h7F}});
    end
    @(negedge clk);
    digits_in = 24'h123456;
    blank_lz = 1'b0;
    brightness = 4'd15;
    reset_n = 1'b1;
    while (!frame_strobe && n < 100) begin
      @(negedge clk);
      n++;
      cmp++;
      if (h !== {6{7'h7F}} || h !== ex_h) begin
        errs++;
        $display("FAIL reset_mid_dark n=%0d got=%h exp=%h", n, h, {6{7'h7F}});
      end
    end
    @(negedge clk);
    cmp++;
    if (n != FR || h !== {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}) begin
      errs++;
      $display("FAIL reset_mid_restart got n=%0d hex=%h exp n=%0d hex=%h", n, h, FR,
               {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02});
    end
  endtask
  initial begin
    test_reset;
    test_hex_pattern;
    test_lz;
    test_mid_frame;
    test_pwm;
    test_blink;
    test_random;
    test_reset_mid;
    test_random;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
